cpu_run_ctrl: RTL

Run-control sequencer for the 5-stage pipelined CPU on NEXYS3. It drives the CPU's enable, start and active-low reset pins to provide run, pause, single-step and restart. It detects program HALT and counts executed pipeline cycles. It sits between the board button/switch logic and the CPU instance in the top level.

---
 rtl/cpu_run_ctrl_pkg.sv | 23 ++
 rtl/cpu_run_ctrl_sat_counter16.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encodings and defaults for the CPU run-control sequencer.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    CPURST = 3'd0,
    IDLE   = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    STEPW  = 3'd4,
    PAUSED = 3'd5,
    HALTED = 3'd6
  } run_state_e;

  localparam logic [7:0] DEF_HALT_OP     = 8'h08;
  localparam int         DEF_HALT_STABLE = 4;
  localparam int         DEF_RST_CYCLES  = 2;

  // States in which the CPU is allowed to enter/stay in exec.
  function automatic logic is_exec_state(input run_state_e s);
    return (s == RUN) || (s == STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter16.sv
// 16-bit saturating up-counter with synchronous clear; clear beats enable.
module sat_counter16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] count
);

  logic [15:0] count_r;

  // Count register: saturates at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (enable && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/pause/step/restart sequencer for the pipelined CPU with HALT detection.
// Optional breakpoint support is built when CPU_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter logic [7:0] HALT_OP     = DEF_HALT_OP,
  parameter int         HALT_STABLE = DEF_HALT_STABLE,
  parameter int         RST_CYCLES  = DEF_RST_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        pause,
  input  logic        restart,
  input  logic [7:0]  cpu_i_addr,
  input  logic [15:0] cpu_i_data,
`ifdef CPU_BREAKPOINT_EN
  input  logic [7:0]  bp_addr,
  input  logic        bp_valid,
`endif
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic        cpu_reset_n,
  output logic [2:0]  st,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] cycles
);

  run_state_e  state_r, state_s;
  logic [3:0]  rst_cnt_r, rst_cnt_s;
  logic [3:0]  stable_cnt_r, stable_cnt_s;
  logic [7:0]  prev_addr_r;
  logic        cpu_enable_r, cpu_reset_n_r, halted_r, bp_hit_r;
  logic        bp_hit_s, bp_match_s, halt_det_s;
  logic        cyc_inc_s, cyc_clr_s;
  logic        unused_data_s;

  assign unused_data_s = ^cpu_i_data[7:0];

  // HALT detector: consecutive RUN cycles parked on a HALT opcode at one pc.
  always_comb begin
    stable_cnt_s = 4'd0;
    if (restart) begin
      stable_cnt_s = 4'd0;
    end else if ((state_r == RUN) && (cpu_i_addr == prev_addr_r) &&
                 (cpu_i_data[15:8] == HALT_OP)) begin
      stable_cnt_s = stable_cnt_r + 4'd1;
    end else begin
      stable_cnt_s = 4'd0;
    end
  end

  assign halt_det_s = (stable_cnt_s == 4'(HALT_STABLE));

`ifdef CPU_BREAKPOINT_EN
  logic bp_mask_r, bp_mask_s;

  assign bp_match_s = bp_valid && (cpu_i_addr == bp_addr) && !bp_mask_r;

  // Mask keeps a resume at the breakpoint pc from re-hitting until pc moves on.
  always_comb begin
    bp_mask_s = bp_mask_r;
    if (restart) begin
      bp_mask_s = 1'b0;
    end else if ((state_r == PAUSED) && ((state_s == RUN) || (state_s == STEP))) begin
      bp_mask_s = 1'b1;
    end else if (cpu_i_addr != bp_addr) begin
      bp_mask_s = 1'b0;
    end else begin
      bp_mask_s = bp_mask_r;
    end
  end

  // Breakpoint mask register.
  always_ff @(posedge clock) begin
    if (reset) begin
      bp_mask_r <= 1'b0;
    end else begin
      bp_mask_r <= bp_mask_s;
    end
  end
`else
  assign bp_match_s = 1'b0;
`endif

  // Next-state logic; restart outranks every other command.
  always_comb begin
    state_s   = state_r;
    rst_cnt_s = rst_cnt_r;
    bp_hit_s  = 1'b0;
    cyc_inc_s = 1'b0;
    cyc_clr_s = 1'b0;
    if (restart) begin
      state_s   = CPURST;
      rst_cnt_s = 4'd0;
      cyc_clr_s = 1'b1;
    end else begin
      case (state_r)
        CPURST: begin
          if (rst_cnt_r >= 4'(RST_CYCLES - 1)) begin
            state_s   = IDLE;
            rst_cnt_s = 4'd0;
          end else begin
            rst_cnt_s = rst_cnt_r + 4'd1;
          end
        end
        IDLE, PAUSED: begin
          if (pause) begin
            state_s = state_r;
          end else if (step) begin
            state_s = STEP;
          end else if (run) begin
            state_s = RUN;
          end else begin
            state_s = state_r;
          end
        end
        RUN: begin
          cyc_inc_s = 1'b1;
          if (pause) begin
            state_s = PAUSED;
          end else if (halt_det_s) begin
            state_s = HALTED;
          end else if (bp_match_s) begin
            state_s  = PAUSED;
            bp_hit_s = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
        STEP:   state_s = STEPW;
        STEPW: begin
          cyc_inc_s = 1'b1;
          state_s   = PAUSED;
        end
        HALTED: state_s = HALTED;
        default: begin
          state_s   = CPURST;
          rst_cnt_s = 4'd0;
        end
      endcase
    end
  end

  // State, detector and registered CPU-facing outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= CPURST;
      rst_cnt_r     <= 4'd0;
      stable_cnt_r  <= 4'd0;
      prev_addr_r   <= 8'd0;
      cpu_enable_r  <= 1'b0;
      cpu_reset_n_r <= 1'b0;
      halted_r      <= 1'b0;
      bp_hit_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      rst_cnt_r     <= rst_cnt_s;
      stable_cnt_r  <= stable_cnt_s;
      prev_addr_r   <= cpu_i_addr;
      cpu_enable_r  <= is_exec_state(state_s);
      cpu_reset_n_r <= (state_s != CPURST);
      halted_r      <= (state_s == HALTED);
      bp_hit_r      <= bp_hit_s;
    end
  end

  sat_counter16 u_cycles (
    .clock  (clock),
    .reset  (reset),
    .clear  (cyc_clr_s),
    .enable (cyc_inc_s),
    .count  (cycles)
  );

  assign cpu_enable  = cpu_enable_r;
  assign cpu_start   = cpu_enable_r;
  assign cpu_reset_n = cpu_reset_n_r;
  assign st          = state_r;
  assign halted      = halted_r;
  assign bp_hit      = bp_hit_r;

endmodule
